// File: rtl/esn_step_ctrl.sv
// Sequencer for one PE tile: runs n_steps reservoir updates, each split into N_GRP block-MVM passes
// (fetch weight word, run PE for PE_LAT cycles, capture outputs), then commits the next-state buffer.
module esn_step_ctrl #(
    parameter int WORD_LEN = 16,
    parameter int NEU_IN   = 8,
    parameter int NEU_OUT  = 4,
    parameter int N_GRP    = 2,
    parameter int PE_LAT   = 2,
    parameter int STEP_W   = 8,
    parameter int W_ADDR_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [STEP_W-1:0]             n_steps,
    output logic                          busy,
    output logic                          done,
    input  logic                          st_we,
    input  logic [$clog2(NEU_IN)-1:0]     st_addr,
    input  logic [WORD_LEN-1:0]           st_din,
    output logic [WORD_LEN*NEU_IN-1:0]    state_q,
    output logic                          w_rd,
    output logic [W_ADDR_W-1:0]           w_addr,
    output logic                          pe_ce,
    output logic [1:0]                    pe_mode,
    input  logic [WORD_LEN*NEU_OUT-1:0]   pe_q
);
    localparam int ST_AW = $clog2(NEU_IN);
    localparam int CNT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam int GRP_BITS = WORD_LEN * NEU_OUT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_CAPT,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t                      st, nst;
    logic [STEP_W-1:0]           n_lat;
    logic [STEP_W-1:0]           steps_done;
    logic [STEP_W-1:0]           steps_nxt;
    logic [W_ADDR_W-1:0]         grp;
    logic [CNT_W-1:0]            ecnt;
    logic [WORD_LEN*NEU_IN-1:0]  nxt_buf;

    assign steps_nxt = steps_done + STEP_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_IDLE;
        end else begin
            st <= nst;
        end
    end

    always_comb begin
        nst     = st;
        busy    = 1'b0;
        done    = 1'b0;
        w_rd    = 1'b0;
        pe_ce   = 1'b0;
        w_addr  = grp;
        pe_mode = 2'b01;
        case (st)
            S_IDLE: begin
                if (start) begin
                    nst = (n_steps != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                w_rd = 1'b1;
                nst  = S_EXEC;
            end
            S_EXEC: begin
                busy  = 1'b1;
                pe_ce = 1'b1;
                if (ecnt == CNT_W'(PE_LAT - 1)) begin
                    nst = S_CAPT;
                end
            end
            S_CAPT: begin
                busy = 1'b1;
                nst  = (grp == W_ADDR_W'(N_GRP - 1)) ? S_COMMIT : S_FETCH;
            end
            S_COMMIT: begin
                busy = 1'b1;
                nst  = (steps_nxt == n_lat) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done = 1'b1;
                nst  = S_IDLE;
            end
            default: nst = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= '0;
            nxt_buf    <= '0;
            n_lat      <= '0;
            steps_done <= '0;
            grp        <= '0;
            ecnt       <= '0;
        end else begin
            ecnt <= (st == S_EXEC) ? ecnt + CNT_W'(1) : '0;
            case (st)
                S_IDLE: begin
                    // Host write lands before a same-cycle start, so the run sees it.
                    if (st_we) begin
                        for (int i = 0; i < NEU_IN; i++) begin
                            if (st_addr == ST_AW'(i)) begin
                                state_q[i*WORD_LEN +: WORD_LEN] <= st_din;
                            end
                        end
                    end
                    if (start && (n_steps != '0)) begin
                        n_lat      <= n_steps;
                        steps_done <= '0;
                        grp        <= '0;
                    end
                end
                S_CAPT: begin
                    for (int g = 0; g < N_GRP; g++) begin
                        if (grp == W_ADDR_W'(g)) begin
                            nxt_buf[g*GRP_BITS +: GRP_BITS] <= pe_q;
                        end
                    end
                    if (grp != W_ADDR_W'(N_GRP - 1)) begin
                        grp <= grp + W_ADDR_W'(1);
                    end
                end
                S_COMMIT: begin
                    state_q    <= nxt_buf;
                    grp        <= '0;
                    steps_done <= steps_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_esn_step_ctrl.sv
// Bench for esn_step_ctrl: table-driven runs, multi-cycle corner sequences and randomized runs
// checked against a step-level reference model of the reservoir update.
module tb_esn_step_ctrl;
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    n_steps;
    logic          busy, done;
    logic          st_we;
    logic [2:0]    st_addr;
    logic [15:0]   st_din;
    logic [127:0]  state_q;
    logic          w_rd;
    logic [3:0]    w_addr;
    logic          pe_ce;
    logic [1:0]    pe_mode;
    logic [63:0]   pe_q;

    always #5 clk = ~clk;

    esn_step_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .n_steps(n_steps), .busy(busy), .done(done),
        .st_we(st_we), .st_addr(st_addr), .st_din(st_din), .state_q(state_q),
        .w_rd(w_rd), .w_addr(w_addr), .pe_ce(pe_ce), .pe_mode(pe_mode), .pe_q(pe_q)
    );

    // PE model: sel 0 -> group constants; sel 1 -> out word j = D[(grp*4+j+rot)%8] ^ key.
    int          pe_sel;
    int          rot;
    logic [15:0] key;
    logic [63:0] p1;

    function automatic logic [63:0] pe_fn(input logic [3:0] g, input logic [127:0] s);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            if (pe_sel == 0) r[j*16 +: 16] = (g == 4'd0) ? 16'h1111 : 16'h2222;
            else r[j*16 +: 16] = s[((int'(g) * 4 + j + rot) % 8) * 16 +: 16] ^ key;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (pe_ce) begin
            p1   <= pe_fn(w_addr, state_q);
            pe_q <= p1;
        end
    end

    int n_chk, n_fail;
    int cnt_wrd, cnt_ce, cnt_done, cnt_busy, mode_bad;
    int addr_q[$];

    task automatic check_v(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (w_rd) begin
            cnt_wrd++;
            addr_q.push_back(int'(w_addr));
        end
        if (pe_ce) cnt_ce++;
        if (done) cnt_done++;
        if (busy) cnt_busy++;
        if (pe_mode !== 2'b01) mode_bad++;
    endtask

    task automatic clr();
        cnt_wrd = 0; cnt_ce = 0; cnt_done = 0; cnt_busy = 0;
        addr_q.delete();
    endtask

    task automatic load(input int i, input logic [15:0] d);
        st_we = 1'b1; st_addr = 3'(i); st_din = d;
        cyc();
        st_we = 1'b0;
    endtask

    task automatic load_pat();
        for (int i = 0; i < 8; i++) load(i, 16'(i * 256));
    endtask

    // Latency counts clock cycles from the start-accept edge to the cycle where done is seen.
    task automatic run(input logic [7:0] n, input bit hold, input int wr_at, output int lat);
        clr();
        start = 1'b1; n_steps = n;
        cyc();
        lat = 1;
        st_we = 1'b0;
        start = hold;
        while (!done && lat < 5000) begin
            if (lat == wr_at) begin
                st_we = 1'b1; st_addr = 3'd0; st_din = 16'hDEAD;
            end else begin
                st_we = 1'b0;
            end
            cyc();
            lat++;
        end
        start = 1'b0; st_we = 1'b0;
        cyc();
    endtask

    typedef struct {
        logic [7:0]   n;
        int           sel;
        int           lat;
        int           wrd;
        int           bsy;
        logic [127:0] st;
    } vec_t;

    vec_t         tbl[5];
    logic [127:0] pat, cst;
    logic [15:0]  ref_s[8];
    logic [15:0]  tmp[8];
    logic [127:0] ref_v;
    int           lat, n;

    initial begin
        n_chk = 0; n_fail = 0; mode_bad = 0;
        clr();
        rst = 1'b1; start = 1'b0; n_steps = '0; st_we = 1'b0; st_addr = '0; st_din = '0;
        pe_sel = 1; rot = 0; key = '0;

        for (int i = 0; i < 8; i++) pat[i*16 +: 16] = 16'(i * 256);
        cst = {{4{16'h2222}}, {4{16'h1111}}};
        tbl[0] = '{n: 8'd1,   sel: 1, lat: 10,   wrd: 2,   bsy: 9,    st: pat};
        tbl[1] = '{n: 8'd3,   sel: 0, lat: 28,   wrd: 6,   bsy: 27,   st: cst};
        tbl[2] = '{n: 8'd0,   sel: 1, lat: 1,    wrd: 0,   bsy: 0,    st: pat};
        tbl[3] = '{n: 8'd2,   sel: 1, lat: 19,   wrd: 4,   bsy: 18,   st: pat};
        tbl[4] = '{n: 8'd255, sel: 1, lat: 2296, wrd: 510, bsy: 2295, st: pat};

        repeat (2) @(negedge clk);
        check_i("rst_busy", int'(busy), 0);
        check_i("rst_done", int'(done), 0);
        check_i("rst_w_rd", int'(w_rd), 0);
        check_i("rst_pe_ce", int'(pe_ce), 0);
        check_i("rst_w_addr", int'(w_addr), 0);
        check_i("rst_pe_mode", int'(pe_mode), 1);
        check_v("rst_state", state_q, '0);
        rst = 1'b0;
        cyc();

        foreach (tbl[r]) begin
            load_pat();
            pe_sel = tbl[r].sel; rot = 0; key = '0;
            run(tbl[r].n, 1'b0, -1, lat);
            check_i($sformatf("tbl%0d_latency", r), lat, tbl[r].lat);
            check_i($sformatf("tbl%0d_w_rd", r), cnt_wrd, tbl[r].wrd);
            check_i($sformatf("tbl%0d_pe_ce", r), cnt_ce, 2 * tbl[r].wrd);
            check_i($sformatf("tbl%0d_busy", r), cnt_busy, tbl[r].bsy);
            check_i($sformatf("tbl%0d_done", r), cnt_done, 1);
            check_v($sformatf("tbl%0d_state", r), state_q, tbl[r].st);
            if (r < 2) begin
                foreach (addr_q[k]) check_i($sformatf("tbl%0d_addr%0d", r, k), addr_q[k], k % 2);
            end
        end

        // Async reset while the first EXEC cycle is in progress.
        load_pat();
        pe_sel = 1;
        clr();
        start = 1'b1; n_steps = 8'd1;
        cyc();
        start = 1'b0;
        cyc();
        check_i("mid_pe_ce_pre", int'(pe_ce), 1);
        rst = 1'b1;
        #1;
        check_i("mid_rst_busy", int'(busy), 0);
        check_i("mid_rst_pe_ce", int'(pe_ce), 0);
        check_v("mid_rst_state", state_q, '0);
        cyc();
        rst = 1'b0;
        repeat (12) cyc();
        check_i("mid_rst_no_done", cnt_done, 0);
        check_i("mid_rst_idle", int'(busy), 0);

        // start held through the run plus a mid-run host write that must be ignored.
        load_pat();
        load(0, 16'h1234);
        pe_sel = 1; rot = 0; key = '0;
        run(8'd1, 1'b1, 4, lat);
        repeat (3) cyc();
        check_i("hold_done_once", cnt_done, 1);
        check_i("hold_w_rd", cnt_wrd, 2);
        check_i("hold_idle", int'(busy), 0);
        check_v("hold_word0", 128'(state_q[15:0]), 128'(16'h1234));

        // Host write in the same cycle as start.
        load_pat();
        st_we = 1'b1; st_addr = 3'd7; st_din = 16'h7FFF;
        run(8'd1, 1'b0, -1, lat);
        check_v("same_cyc_word7", 128'(state_q[127:112]), 128'(16'h7FFF));
        check_v("same_cyc_word6", 128'(state_q[111:96]), 128'(16'h0600));

        // Randomized runs against the step-level model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) begin
                ref_s[i] = 16'($urandom);
                load(i, ref_s[i]);
            end
            n = $urandom_range(1, 4);
            rot = $urandom_range(0, 7);
            key = 16'($urandom);
            pe_sel = 1;
            for (int s = 0; s < n; s++) begin
                for (int i = 0; i < 8; i++) tmp[i] = ref_s[(i + rot) % 8] ^ key;
                ref_s = tmp;
            end
            for (int i = 0; i < 8; i++) ref_v[i*16 +: 16] = ref_s[i];
            run(8'(n), 1'b0, -1, lat);
            check_v($sformatf("rnd%0d_state", r), state_q, ref_v);
            check_i($sformatf("rnd%0d_latency", r), lat, 9 * n + 1);
            check_i($sformatf("rnd%0d_w_rd", r), cnt_wrd, 2 * n);
        end

        check_i("pe_mode_always_01", mode_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
